// File: rtl/phys_reg_freelist_pkg.sv
// Shared widths, types and helpers for the physical register freelist.
// Optional flush recovery in the top is enabled with RENAME_FLUSH_EN.
package phys_reg_freelist_pkg;

  localparam int unsigned DISPATCH_WIDTH       = 2;
  localparam int unsigned PHYS_REGS            = 64;
  localparam int unsigned PHYS_REGS_ADDR_WIDTH = 6;
  localparam int unsigned FL_CNT_WIDTH         = PHYS_REGS_ADDR_WIDTH + 1;
  localparam int unsigned ARCH_REGS            = 32;
  localparam int unsigned ARCH_ADDR_WIDTH      = 5;
  localparam int unsigned FREE_REGS            = PHYS_REGS - ARCH_REGS;

  typedef logic [PHYS_REGS_ADDR_WIDTH-1:0] phys_addr_t;
  typedef logic [ARCH_ADDR_WIDTH-1:0]      arch_addr_t;
  typedef logic [FL_CNT_WIDTH-1:0]         fl_cnt_t;

  // One ROB commit lane as seen by the commit map.
  typedef struct packed {
    logic       en;
    arch_addr_t arch_rd;
    phys_addr_t phys_rd;
  } commit_lane_t;

  function automatic fl_cnt_t popcount(input logic [DISPATCH_WIDTH-1:0] v);
    fl_cnt_t n;
    n = '0;
    for (int unsigned i = 0; i < DISPATCH_WIDTH; i++) begin
      n = n + fl_cnt_t'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/phys_reg_freelist_commit_map.sv
// Committed arch->phys map; returns the mapping each retiring rd displaces.
// Lanes are applied in order, so a later lane sees an earlier lane's same-cycle write.
module phys_reg_freelist_commit_map
  import phys_reg_freelist_pkg::*;
(
  input  logic                             clk,
  input  logic                             rst,
  input  commit_lane_t [DISPATCH_WIDTH-1:0] commit_i,
  output logic [DISPATCH_WIDTH-1:0]        free_vld_c_o,
  output phys_addr_t [DISPATCH_WIDTH-1:0]  old_phys_rd_c_o
);

  phys_addr_t map_q [ARCH_REGS];
  phys_addr_t map_d [ARCH_REGS];

  // Reading map_d (not map_q) forwards earlier lanes' writes to later lanes.
  always_comb begin
    map_d           = map_q;
    free_vld_c_o    = '0;
    old_phys_rd_c_o = '0;
    for (int unsigned i = 0; i < DISPATCH_WIDTH; i++) begin
      free_vld_c_o[i]    = commit_i[i].en && (commit_i[i].arch_rd != '0);
      old_phys_rd_c_o[i] = map_d[commit_i[i].arch_rd];
      if (free_vld_c_o[i]) begin
        map_d[commit_i[i].arch_rd] = commit_i[i].phys_rd;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < ARCH_REGS; i++) begin
        map_q[i] <= PHYS_REGS_ADDR_WIDTH'(i);
      end
    end else begin
      map_q <= map_d;
    end
  end

endmodule

// File: rtl/phys_reg_freelist.sv
// Circular freelist of physical registers: all-or-nothing allocation, commit-driven reclaim.
// Define RENAME_FLUSH_EN to add flush_i, which rewinds head to the commit point.
module phys_reg_freelist
  import phys_reg_freelist_pkg::*;
(
  input  logic                            clk,
  input  logic                            rst,
  input  logic [DISPATCH_WIDTH-1:0]       alloc_req_i,
  output phys_addr_t [DISPATCH_WIDTH-1:0] alloc_phys_rd_c_o,
  output logic                            alloc_stall_c_o,
  input  logic [DISPATCH_WIDTH-1:0]       commit_en_i,
  input  arch_addr_t [DISPATCH_WIDTH-1:0] commit_arch_rd_i,
  input  phys_addr_t [DISPATCH_WIDTH-1:0] commit_phys_rd_i,
`ifdef RENAME_FLUSH_EN
  input  logic                            flush_i,
`endif
  output fl_cnt_t                         free_count_o
);

  phys_addr_t fifo_q [PHYS_REGS];
  phys_addr_t fifo_d [PHYS_REGS];
  phys_addr_t head_q, head_d;
  phys_addr_t tail_q, tail_d;
  fl_cnt_t    count_q, count_d;
`ifdef RENAME_FLUSH_EN
  phys_addr_t commit_head_q, commit_head_d;
`endif

  commit_lane_t [DISPATCH_WIDTH-1:0] commit_lanes;
  logic [DISPATCH_WIDTH-1:0]         free_vld;
  phys_addr_t [DISPATCH_WIDTH-1:0]   old_phys_rd;
  fl_cnt_t                           n_req;
  fl_cnt_t                           n_free;

  always_comb begin
    commit_lanes = '0;
    for (int unsigned i = 0; i < DISPATCH_WIDTH; i++) begin
      commit_lanes[i].en      = commit_en_i[i];
      commit_lanes[i].arch_rd = commit_arch_rd_i[i];
      commit_lanes[i].phys_rd = commit_phys_rd_i[i];
    end
  end

  phys_reg_freelist_commit_map u_commit_map (
    .clk             (clk),
    .rst             (rst),
    .commit_i        (commit_lanes),
    .free_vld_c_o    (free_vld),
    .old_phys_rd_c_o (old_phys_rd)
  );

  assign n_req  = popcount(alloc_req_i);
  assign n_free = popcount(free_vld);

  // Lanes pick consecutive entries from head, skipping non-requesting lanes.
  always_comb begin
    phys_addr_t rd_off;
    rd_off            = '0;
    alloc_phys_rd_c_o = '0;
    for (int unsigned i = 0; i < DISPATCH_WIDTH; i++) begin
      alloc_phys_rd_c_o[i] = fifo_q[head_q + rd_off];
      if (alloc_req_i[i]) begin
        rd_off = rd_off + phys_addr_t'(1);
      end
    end
  end

  always_comb begin
    alloc_stall_c_o = (n_req > count_q);
`ifdef RENAME_FLUSH_EN
    if (flush_i) begin
      alloc_stall_c_o = 1'b1;
    end
`endif
  end

  // Pointer, count and FIFO update; freed regs land at tail in lane order.
  always_comb begin
    phys_addr_t wr_off;
    wr_off  = '0;
    fifo_d  = fifo_q;
    head_d  = head_q;
    count_d = count_q + n_free;
    for (int unsigned i = 0; i < DISPATCH_WIDTH; i++) begin
      if (free_vld[i]) begin
        fifo_d[tail_q + wr_off] = old_phys_rd[i];
        wr_off = wr_off + phys_addr_t'(1);
      end
    end
    tail_d = tail_q + phys_addr_t'(n_free);
    if (!alloc_stall_c_o) begin
      head_d  = head_q + phys_addr_t'(n_req);
      count_d = count_q - n_req + n_free;
    end
`ifdef RENAME_FLUSH_EN
    commit_head_d = commit_head_q + phys_addr_t'(n_free);
    // Squashed allocations between commit_head and head become free again.
    if (flush_i) begin
      head_d  = commit_head_d;
      count_d = fl_cnt_t'(phys_addr_t'(tail_d - commit_head_d));
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < PHYS_REGS; i++) begin
        fifo_q[i] <= (i < FREE_REGS) ? PHYS_REGS_ADDR_WIDTH'(i + ARCH_REGS) : '0;
      end
      head_q  <= '0;
      tail_q  <= PHYS_REGS_ADDR_WIDTH'(FREE_REGS);
      count_q <= FL_CNT_WIDTH'(FREE_REGS);
    end else begin
      fifo_q  <= fifo_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

`ifdef RENAME_FLUSH_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      commit_head_q <= '0;
    end else begin
      commit_head_q <= commit_head_d;
    end
  end
`endif

  assign free_count_o = count_q;

  // More frees than outstanding allocations means the ROB broke protocol.
  assert property (@(posedge clk) disable iff (rst)
                   (32'(count_q) + 32'(n_free) <= FREE_REGS))
    else $error("phys_reg_freelist: push beyond capacity count=%0d n_free=%0d", count_q, n_free);

endmodule

// File: tb/tb_phys_reg_freelist.sv
// Self-checking bench: directed vector table plus randomized traffic against a queue model.
module tb_phys_reg_freelist;
  import phys_reg_freelist_pkg::*;

  logic                            clk = 1'b0;
  logic                            rst;
  logic [DISPATCH_WIDTH-1:0]       alloc_req;
  phys_addr_t [DISPATCH_WIDTH-1:0] alloc_rd;
  logic                            stall;
  logic [DISPATCH_WIDTH-1:0]       commit_en;
  arch_addr_t [DISPATCH_WIDTH-1:0] commit_arch;
  phys_addr_t [DISPATCH_WIDTH-1:0] commit_phys;
  fl_cnt_t                         free_count;
`ifdef RENAME_FLUSH_EN
  logic                            flush;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  phys_reg_freelist dut (
    .clk               (clk),
    .rst               (rst),
    .alloc_req_i       (alloc_req),
    .alloc_phys_rd_c_o (alloc_rd),
    .alloc_stall_c_o   (stall),
    .commit_en_i       (commit_en),
    .commit_arch_rd_i  (commit_arch),
    .commit_phys_rd_i  (commit_phys),
`ifdef RENAME_FLUSH_EN
    .flush_i           (flush),
`endif
    .free_count_o      (free_count)
  );

  typedef struct {
    logic [1:0] req;
    logic [1:0] en;
    int         a0, a1, p0, p1;
    logic       stall;
    int         rd0, rd1;
    int         cnt;
  } vec_t;

  vec_t vecs[$];

  // Behavioural model: free queue, in-flight allocations in order, committed map.
  int fq[$];
  int inf[$];
  int amap[ARCH_REGS];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic void add(input logic [1:0] req, input logic [1:0] en,
                              input int a0, input int a1, input int p0, input int p1,
                              input logic st, input int rd0, input int rd1, input int cnt);
    vec_t v;
    v.req = req; v.en = en; v.a0 = a0; v.a1 = a1; v.p0 = p0; v.p1 = p1;
    v.stall = st; v.rd0 = rd0; v.rd1 = rd1; v.cnt = cnt;
    vecs.push_back(v);
  endfunction

  task automatic drive(input logic [1:0] req, input logic [1:0] en, input int a0, input int a1,
                       input int p0, input int p1, input logic fl);
    alloc_req      = req;
    commit_en      = en;
    commit_arch[0] = arch_addr_t'(a0);
    commit_arch[1] = arch_addr_t'(a1);
    commit_phys[0] = phys_addr_t'(p0);
    commit_phys[1] = phys_addr_t'(p1);
`ifdef RENAME_FLUSH_EN
    flush = fl;
`else
    if (fl) $display("FAIL flush requested without flush support");
`endif
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    drive(2'b00, 2'b00, 0, 0, 0, 0, 1'b0);
    #1;
    chk("rst.count", int'(free_count), 32);
    chk("rst.stall", int'(stall), 0);
    alloc_req = 2'b11;
    #1;
    chk("rst.rd0", int'(alloc_rd[0]), 32);
    chk("rst.rd1", int'(alloc_rd[1]), 33);
    @(negedge clk);
    rst = 1'b0;
    alloc_req = 2'b00;
    fq.delete();
    inf.delete();
    for (int i = 0; i < 32; i++) begin
      fq.push_back(32 + i);
      amap[i] = i;
    end
  endtask

  task automatic step_chk(input string tag, input logic [1:0] req, input logic [1:0] en,
                          input int a0, input int a1, input int p0, input int p1, input logic fl,
                          input logic est, input int rd0, input int rd1, input int cnt);
    @(negedge clk);
    drive(req, en, a0, a1, p0, p1, fl);
    #2;
    chk({tag, ".stall"}, int'(stall), int'(est));
    chk({tag, ".count"}, int'(free_count), cnt);
    if (!est && req[0]) chk({tag, ".rd0"}, int'(alloc_rd[0]), rd0);
    if (!est && req[1]) chk({tag, ".rd1"}, int'(alloc_rd[1]), rd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    drive(2'b00, 2'b00, 0, 0, 0, 0, 1'b0);

    // Directed vectors from reset: allocation order, commit/free, forwarding, stall.
    add(2'b11, 2'b00, 0, 0, 0, 0, 1'b0, 32, 33, 32);
    add(2'b11, 2'b00, 0, 0, 0, 0, 1'b0, 34, 35, 30);
    add(2'b01, 2'b00, 0, 0, 0, 0, 1'b0, 36, 0, 28);
    add(2'b10, 2'b00, 0, 0, 0, 0, 1'b0, 0, 37, 27);
    add(2'b00, 2'b01, 5, 0, 40, 0, 1'b0, 0, 0, 26);
    add(2'b00, 2'b11, 7, 7, 41, 42, 1'b0, 0, 0, 27);
    add(2'b00, 2'b01, 0, 3, 43, 44, 1'b0, 0, 0, 29);
    add(2'b11, 2'b00, 0, 0, 0, 0, 1'b0, 38, 39, 29);
    add(2'b11, 2'b11, 9, 10, 38, 39, 1'b0, 40, 41, 27);
    add(2'b00, 2'b00, 0, 0, 0, 0, 1'b0, 0, 0, 27);
    for (int k = 0; k < 11; k++) add(2'b11, 2'b00, 0, 0, 0, 0, 1'b0, 42 + 2*k, 43 + 2*k, 27 - 2*k);
    add(2'b11, 2'b00, 0, 0, 0, 0, 1'b0, 5, 7, 5);
    add(2'b11, 2'b00, 0, 0, 0, 0, 1'b0, 41, 9, 3);
    add(2'b11, 2'b00, 0, 0, 0, 0, 1'b1, 0, 0, 1);
    add(2'b01, 2'b00, 0, 0, 0, 0, 1'b0, 10, 0, 1);
    add(2'b01, 2'b00, 0, 0, 0, 0, 1'b1, 0, 0, 0);
    add(2'b00, 2'b11, 7, 5, 50, 51, 1'b0, 0, 0, 0);
    add(2'b11, 2'b00, 0, 0, 0, 0, 1'b0, 42, 40, 2);
    add(2'b00, 2'b11, 3, 3, 52, 53, 1'b0, 0, 0, 0);
    add(2'b10, 2'b00, 0, 0, 0, 0, 1'b0, 0, 3, 2);
    add(2'b01, 2'b00, 0, 0, 0, 0, 1'b0, 52, 0, 1);
    add(2'b00, 2'b00, 0, 0, 0, 0, 1'b0, 0, 0, 0);

    do_reset();
    for (int k = 0; k < vecs.size(); k++) begin
      step_chk($sformatf("vec%0d", k), vecs[k].req, vecs[k].en, vecs[k].a0, vecs[k].a1,
               vecs[k].p0, vecs[k].p1, 1'b0, vecs[k].stall, vecs[k].rd0, vecs[k].rd1, vecs[k].cnt);
    end

    // Reset in the middle of traffic must restore the initial state at once.
    do_reset();

`ifdef RENAME_FLUSH_EN
    step_chk("fl0", 2'b11, 2'b00, 0, 0, 0, 0, 1'b0, 1'b0, 32, 33, 32);
    step_chk("fl1", 2'b11, 2'b00, 0, 0, 0, 0, 1'b0, 1'b0, 34, 35, 30);
    step_chk("fl2", 2'b00, 2'b01, 1, 0, 32, 0, 1'b0, 1'b0, 0, 0, 28);
    step_chk("fl3", 2'b11, 2'b00, 0, 0, 0, 0, 1'b1, 1'b1, 0, 0, 29);
    step_chk("fl4", 2'b11, 2'b00, 0, 0, 0, 0, 1'b0, 1'b0, 33, 34, 32);
    do_reset();
`endif

    // Randomized traffic; commits retire in-flight regs in allocation order.
    for (int c = 0; c < 3000; c++) begin
      logic [1:0] req;
      logic [1:0] en;
      int a[2];
      int p[2];
      int used;
      int nreq;
      int k;
      logic fl;
      logic est;
      req  = 2'($urandom_range(0, 3));
      en   = 2'b00;
      used = 0;
      fl   = 1'b0;
`ifdef RENAME_FLUSH_EN
      fl = ($urandom_range(0, 31) == 0);
`endif
      for (int l = 0; l < 2; l++) begin
        int r;
        r    = int'($urandom_range(0, 3));
        a[l] = int'($urandom_range(0, 31));
        p[l] = int'($urandom_range(0, 63));
        if (r == 1) begin
          en[l] = 1'b1;
          a[l]  = 0;
        end else if (r >= 2 && used < inf.size()) begin
          en[l] = 1'b1;
          a[l]  = int'($urandom_range(1, 31));
          p[l]  = inf[used];
          used++;
        end
      end
      @(negedge clk);
      drive(req, en, a[0], a[1], p[0], p[1], fl);
      #2;
      nreq = int'(req[0]) + int'(req[1]);
      est  = fl || (nreq > fq.size());
      chk($sformatf("rnd%0d.stall", c), int'(stall), int'(est));
      chk($sformatf("rnd%0d.count", c), int'(free_count), fq.size());
      k = 0;
      for (int l = 0; l < 2; l++) begin
        if (!est && req[l]) begin
          chk($sformatf("rnd%0d.rd%0d", c, l), int'(alloc_rd[l]), fq[k]);
          k++;
        end
      end
      if (!est) begin
        for (int j = 0; j < nreq; j++) inf.push_back(fq.pop_front());
      end
      for (int l = 0; l < 2; l++) begin
        if (en[l] && a[l] != 0) begin
          fq.push_back(amap[a[l]]);
          amap[a[l]] = p[l];
          void'(inf.pop_front());
        end
      end
      if (fl) begin
        fq = {inf, fq};
        inf.delete();
      end
    end

    @(negedge clk);
    drive(2'b00, 2'b00, 0, 0, 0, 0, 1'b0);
    #2;
    chk("final.count", int'(free_count), fq.size());

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/phys_reg_freelist.md
Name: phys_reg_freelist

Overview:
- Supplies free physical destination registers to rename/dispatch and reclaims them when instructions retire.
- Sits on the ROB commit port. It consumes commit_en/commit_arch_rd/commit_phys_rd and produces the dispatch_phys_rd that the ROB accepts at dispatch.
- Keeps the committed architectural map (arch reg -> phys reg) so it can free the previous mapping of each retiring rd.
- Free registers are held in a circular FIFO of physical register numbers.

Parameters:
DISPATCH_WIDTH, 2, allocation and commit lanes per cycle
PHYS_REGS, 64, number of physical registers (power of two, > 32)
PHYS_REGS_ADDR_WIDTH, 6, log2(PHYS_REGS)
FL_CNT_WIDTH, 7, log2(PHYS_REGS)+1, occupancy counter width

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
alloc_req  in  [DISPATCH_WIDTH] x 1  lane i wants a phys rd
alloc_phys_rd  out  [DISPATCH_WIDTH] x PHYS_REGS_ADDR_WIDTH  allocated reg per lane (combinational)
alloc_stall  out  1  not enough free regs; nothing is allocated this cycle
commit_en  in  [DISPATCH_WIDTH] x 1  from ROB commit port
commit_arch_rd  in  [DISPATCH_WIDTH] x 5  retiring arch rd
commit_phys_rd  in  [DISPATCH_WIDTH] x PHYS_REGS_ADDR_WIDTH  retiring phys rd
free_count  out  FL_CNT_WIDTH  current free-register count
flush  in  1  only when RENAME_FLUSH_EN is defined

Behaviour:
- One clock, clk. rst is asynchronous and active-high.
- Reset state:
  - commit map arch i -> phys i for i = 0..31.
  - FIFO entries 0..PHYS_REGS-33 hold phys 32..PHYS_REGS-1.
  - head = 0, tail = PHYS_REGS-32, free_count = PHYS_REGS-32.
  - alloc_stall = 0; alloc_phys_rd lanes show the FIFO at head (32, 33).
- Allocation (combinational outputs, registered pointer):
  - n_req = popcount(alloc_req).
  - Lane i gets fifo[head + popcount(alloc_req[0..i-1])], mod PHYS_REGS.
  - alloc_phys_rd on lanes without a request is don't-care.
  - alloc_stall = (n_req > free_count). Allocation is all-or-nothing: on stall, head and count do not change.
  - Otherwise head += n_req at the clock edge.
- Commit (registered):
  - A lane with commit_en = 1 and commit_arch_rd != 0 frees old = map[arch_rd], then writes map[arch_rd] = commit_phys_rd.
  - Same-cycle forwarding: if lane j > i has the same arch_rd as lane i, lane j's old mapping is lane i's commit_phys_rd, not map[].
  - Freed regs are written at tail in lane order, then tail += n_free.
  - Lanes with arch_rd == 0, or commit_en = 0, free nothing and do not touch the map.
- Simultaneous alloc and free: free_count_next = free_count - n_alloc + n_free.
  - Freed regs become allocatable the following cycle; no same-cycle bypass.
- Pointers wrap mod PHYS_REGS.
- The FIFO never overflows: at most PHYS_REGS-32 regs are ever free or in flight.
- Pushing when free_count + n_free > PHYS_REGS-32 is a protocol error; a simulation assertion flags it.
- Reset asserted mid-operation restores the full reset state immediately. Pending allocations are lost.

Optional Feature:
- Macro RENAME_FLUSH_EN.
- When defined:
  - Adds the flush port and a commit_head pointer (reset 0). commit_head advances by the number of freeing commit lanes each cycle; each retiring rd consumed one allocation in order.
  - On flush: head <= commit_head and free_count <= tail - commit_head (mod, after this cycle's frees). This returns squashed allocations, which remain physically in the FIFO.
  - Allocation is suppressed in the flush cycle; alloc_stall = 1.
- When undefined: no flush port and no commit_head. Misprediction recovery is done elsewhere.

Decomposition:
- Existing parameters package supplies DISPATCH_WIDTH, PHYS_REGS, PHYS_REGS_ADDR_WIDTH.
- Add to the package: FL_CNT_WIDTH, ARCH_REGS = 32, typedef phys_addr_t.
- Sub-module commit_map: 32-entry arch->phys table with DISPATCH_WIDTH read/write lanes and intra-cycle forwarding. It returns the old mappings to the freelist core.

Test Plan:
- Reset, then request both lanes in cycle 1 -> alloc_phys_rd = {32,33}, stall 0; next cycle free_count = 30, outputs {34,35}.
- Allocate until free_count = 1, then request both lanes -> alloc_stall = 1, free_count stays 1, head unchanged; a single-lane request next cycle gets the last reg.
- Commit arch 5 -> phys 40 -> phys 5 is freed and pushed at tail; map[5] = 40; free_count +1 next cycle.
- Same cycle: lane0 commits arch 7 -> 41, lane1 commits arch 7 -> 42 -> frees 7 and 41; map[7] = 42.
- Commit with arch_rd = 0, or commit_en = 0 -> no free, map and count unchanged. Concurrent alloc 2 plus free 2 -> count unchanged.
- RENAME_FLUSH_EN: allocate 4 (32..35), commit 1 (arch 1 -> 32), then flush -> head points at 33, free_count = 32, next allocation returns {33,34}.
